retry_grant_sched: RTL and testbench
====================================

RETRY_GRANT_SCHED -- requirements
Module: retry_grant_sched

Interface
REQ-001 SHALL have parameter SRC_NODE_W, default 4, source-ID width; SRC_NUM = 2**SRC_NODE_W.
REQ-002 SHALL have parameter RTY_ENTRY_NUM, default 8, retry-credit pool size.
REQ-003 SHALL have parameter QoS_CLASS, default 4, number of QoS levels; qos width 4.
REQ-004 SHALL have one clock and an asynchronous active-low reset, as listed here:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
REQ-005 SHALL have these retry-intake ports:
- vld_rty_in  in  1  retry event valid
- rdy_rty_in  out  1  intake ready
- rty_src_id  in  SRC_NODE_W  retried source
- rty_qos  in  4  QoS of retried request
REQ-006 SHALL have this credit-return port:
- vld_crd_rtn  in  1  one retry entry freed
REQ-007 SHALL have these grant-output ports:
- vld_out_grant  out  1  grant valid
- rdy_out_grant  in  1  grant accepted
- grant_des_id  out  SRC_NODE_W  granted source
- grant_qos  out  4  effective QoS of grant
REQ-008 SHALL have these status ports:
- crd_cnt  out  $clog2(RTY_ENTRY_NUM+1)  free credits
- crd_err  out  1  sticky credit overflow

Function
REQ-009 SHALL keep, per source, a 3-bit pending count and a 4-bit QoS register; a retry accept increments the count and overwrites the QoS register.
REQ-010 SHALL drive rdy_rty_in low combinationally when the pending count of rty_src_id is 7, and high otherwise.
REQ-011 SHALL accept a retry when vld_rty_in && rdy_rty_in at a clk edge.
REQ-012 SHALL keep the credit counter, reset to RTY_ENTRY_NUM; a grant handshake decrements it and vld_crd_rtn increments it.
REQ-013 SHALL leave the counter unchanged when a grant handshake and vld_crd_rtn occur in the same cycle.
REQ-014 SHALL ignore vld_crd_rtn when the counter equals RTY_ENTRY_NUM and no grant handshake occurs that cycle, and SHALL set crd_err, which stays set until reset.
REQ-015 SHALL implement an FSM with states IDLE and HOLD.
REQ-016 SHALL, in IDLE with credit count > 0 and any pending count > 0, select a winner, register it onto grant_des_id/grant_qos, assert vld_out_grant next cycle, and enter HOLD.
REQ-017 SHALL select the winner as the source with the highest effective QoS; ties are broken round-robin, starting from the source after the last granted source, with index wrap-around from SRC_NUM-1 to 0.
REQ-018 SHALL, in HOLD, keep vld_out_grant, grant_des_id and grant_qos stable until rdy_out_grant.
REQ-019 SHALL, on the HOLD handshake, decrement the winner's pending count, update the round-robin pointer to the winner, and return to IDLE; the earliest next grant is two cycles later.
REQ-020 SHALL apply net-zero change to the pending count when a retry accept and a grant handshake hit the same source in one cycle.
REQ-021 SHALL not issue a grant when the credit count is 0; pending counts are retained.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-HOLD, clear the following, and SHALL drop the in-flight grant without consuming a credit:
- all pending counts, QoS registers and age counters
- round-robin pointer = 0, FSM = IDLE
- vld_out_grant = 0, grant_des_id = 0, grant_qos = 0
- crd_cnt = RTY_ENTRY_NUM, crd_err = 0
REQ-023 SHALL drive rdy_rty_in = 1 during and after reset.

Configuration
REQ-024 SHALL, with RTY_AGING_EN defined, keep a per-source 4-bit age counter:
- incremented on each grant handshake to another source while this source is pending
- cleared when this source is granted
- at 15, the source's effective QoS = QoS_CLASS-1
REQ-025 SHALL, without RTY_AGING_EN, have no age counters, and effective QoS = the stored QoS register.

Structure
REQ-026 SHALL place the FSM state enum, the default parameter constants and the age limit (15) in package retry_pkg.
REQ-027 SHALL implement winner selection as sub-module retry_qos_rr_arb: combinational; inputs pending mask, effective-QoS vector and pointer; outputs winner index and winner-found.

Verification
REQ-028 Bench SHALL cover a single retry with src 3, qos 2 and credits 8: vld_out_grant rises 1 cycle later with grant_des_id=3 and grant_qos=2; after the handshake crd_cnt=7.
REQ-029 Bench SHALL cover QoS priority with src 1 qos 1 and src 5 qos 3 pending: first grant is 5, then 1.
REQ-030 Bench SHALL cover round-robin with srcs 2, 6 and 9 all qos 0 and pointer 6: grants come out 9, 2, 6.
REQ-031 Bench SHALL cover credit exhaustion with 9 pending retries and no returns: exactly 8 grants and crd_cnt=0; one vld_crd_rtn produces a 9th grant.
REQ-032 Bench SHALL cover overflow and backpressure: vld_crd_rtn with crd_cnt=8 sets crd_err=1 and crd_cnt stays 8; 8 retries from src 4 drive rdy_rty_in low after the 7th.
REQ-033 Bench SHALL cover reset mid-HOLD: rst_n low with vld_out_grant=1 clears vld_out_grant, and after release crd_cnt=8 with no grants.

Source files
------------

// File: rtl/retry_pkg.sv
// retry_pkg: shared types and constants for the retry grant scheduler.
//   state_t     - grant FSM states (IDLE, HOLD)
//   *_DEF       - default parameter values for the scheduler
//   AGE_LIMIT   - age count at which a starved source is promoted to top QoS
package retry_pkg;

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int unsigned SRC_NODE_W_DEF    = 4;
  localparam int unsigned RTY_ENTRY_NUM_DEF = 8;
  localparam int unsigned QOS_CLASS_DEF     = 4;

  localparam int unsigned QOS_W  = 4;
  localparam int unsigned PEND_W = 3;
  localparam int unsigned AGE_W  = 4;

  localparam logic [PEND_W-1:0] PEND_MAX  = 3'd7;
  localparam logic [AGE_W-1:0]  AGE_LIMIT = 4'd15;

endpackage

// File: rtl/retry_qos_rr_arb.sv
// retry_qos_rr_arb: combinational QoS-first, round-robin-tiebreak arbiter.
//   pend  - per-source pending mask
//   qos   - per-source effective QoS
//   ptr   - last granted source; search starts at ptr+1 and wraps
//   win   - winning source index
//   found - at least one source is pending
module retry_qos_rr_arb
  import retry_pkg::*;
#(
  parameter int unsigned IDX_W = SRC_NODE_W_DEF
) (
  input  logic [2**IDX_W-1:0]            pend,
  input  logic [2**IDX_W-1:0][QOS_W-1:0] qos,
  input  logic [IDX_W-1:0]               ptr,
  output logic [IDX_W-1:0]               win,
  output logic                           found
);

  localparam int unsigned NUM = 2**IDX_W;

  logic [IDX_W-1:0] idx;
  logic [QOS_W-1:0] best;

  // Visit sources in round-robin order (ptr+1 .. ptr, wrapping); only a
  // strictly higher QoS displaces the current pick, so among equal QoS
  // the first in round-robin order wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    best  = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM; i++) begin
      idx = ptr + IDX_W'(i);
      if (pend[idx] && (!found || qos[idx] > best)) begin
        found = 1'b1;
        win   = idx;
        best  = qos[idx];
      end
    end
  end

endmodule

// File: rtl/retry_grant_sched.sv
// retry_grant_sched: tracks per-source retry requests and issues grants
// against a pool of retry credits, highest effective QoS first with
// round-robin tie-break.
//   clk, rst_n                        - clock, async active-low reset
//   vld_rty_in/rdy_rty_in             - retry intake handshake
//   rty_src_id, rty_qos               - retried source and its QoS
//   vld_crd_rtn                       - one retry credit returned
//   vld_out_grant/rdy_out_grant       - grant handshake
//   grant_des_id, grant_qos           - granted source and effective QoS
//   crd_cnt, crd_err                  - free credits, sticky overflow
// Optional: define RTY_AGING_EN to add per-source starvation aging.
module retry_grant_sched
  import retry_pkg::*;
#(
  parameter int unsigned SRC_NODE_W    = SRC_NODE_W_DEF,
  parameter int unsigned RTY_ENTRY_NUM = RTY_ENTRY_NUM_DEF,
  parameter int unsigned QoS_CLASS     = QOS_CLASS_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   vld_rty_in,
  output logic                                   rdy_rty_in,
  input  logic [SRC_NODE_W-1:0]                  rty_src_id,
  input  logic [QOS_W-1:0]                       rty_qos,
  input  logic                                   vld_crd_rtn,
  output logic                                   vld_out_grant,
  input  logic                                   rdy_out_grant,
  output logic [SRC_NODE_W-1:0]                  grant_des_id,
  output logic [QOS_W-1:0]                       grant_qos,
  output logic [$clog2(RTY_ENTRY_NUM+1)-1:0]     crd_cnt,
  output logic                                   crd_err
);

  localparam int unsigned SRC_NUM = 2**SRC_NODE_W;
  localparam int unsigned CNT_W   = $clog2(RTY_ENTRY_NUM+1);
  localparam logic [CNT_W-1:0] CRD_MAX = CNT_W'(RTY_ENTRY_NUM);
  localparam logic [QOS_W-1:0] QOS_TOP = QOS_W'(QoS_CLASS-1);

  state_t                           state;
  logic [SRC_NUM-1:0][PEND_W-1:0]   pend;
  logic [SRC_NUM-1:0][QOS_W-1:0]    qos_reg;
  logic [SRC_NUM-1:0][QOS_W-1:0]    eff_qos;
  logic [SRC_NUM-1:0]               pend_mask;
  logic [SRC_NODE_W-1:0]            ptr;
  logic [SRC_NODE_W-1:0]            win;
  logic                             found;
  logic                             rty_acc;
  logic                             gnt_hs;

`ifdef RTY_AGING_EN
  logic [SRC_NUM-1:0][AGE_W-1:0]    age;
`endif

  assign rdy_rty_in = (pend[rty_src_id] != PEND_MAX);
  assign rty_acc    = vld_rty_in && rdy_rty_in;
  assign gnt_hs     = (state == HOLD) && rdy_out_grant;

  always_comb begin
    pend_mask = '0;
    eff_qos   = '0;
    for (int unsigned s = 0; s < SRC_NUM; s++) begin
      pend_mask[s] = |pend[s];
`ifdef RTY_AGING_EN
      eff_qos[s]   = (age[s] == AGE_LIMIT) ? QOS_TOP : qos_reg[s];
`else
      eff_qos[s]   = qos_reg[s];
`endif
    end
  end

  retry_qos_rr_arb #(.IDX_W(SRC_NODE_W)) u_arb (
    .pend  (pend_mask),
    .qos   (eff_qos),
    .ptr   (ptr),
    .win   (win),
    .found (found)
  );

  // Retry accept and grant handshake on the same source cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      qos_reg <= '0;
    end else begin
      for (int unsigned s = 0; s < SRC_NUM; s++) begin
        if (rty_acc && rty_src_id == SRC_NODE_W'(s))
          qos_reg[s] <= rty_qos;
        case ({rty_acc && rty_src_id == SRC_NODE_W'(s),
               gnt_hs && grant_des_id == SRC_NODE_W'(s)})
          2'b10:   pend[s] <= pend[s] + 3'd1;
          2'b01:   pend[s] <= pend[s] - 3'd1;
          default: pend[s] <= pend[s];
        endcase
      end
    end
  end

`ifdef RTY_AGING_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (gnt_hs) begin
      for (int unsigned s = 0; s < SRC_NUM; s++) begin
        if (grant_des_id == SRC_NODE_W'(s))
          age[s] <= '0;
        else if (pend_mask[s] && age[s] != AGE_LIMIT)
          age[s] <= age[s] + 4'd1;
      end
    end
  end
`endif

  // Simultaneous grant and return is a net zero; a lone return into a
  // full pool is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crd_cnt <= CRD_MAX;
      crd_err <= 1'b0;
    end else if (gnt_hs && !vld_crd_rtn) begin
      crd_cnt <= crd_cnt - 1'b1;
    end else if (!gnt_hs && vld_crd_rtn) begin
      if (crd_cnt == CRD_MAX)
        crd_err <= 1'b1;
      else
        crd_cnt <= crd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vld_out_grant <= 1'b0;
      grant_des_id  <= '0;
      grant_qos     <= '0;
      ptr           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (crd_cnt != '0 && found) begin
            grant_des_id  <= win;
            grant_qos     <= eff_qos[win];
            vld_out_grant <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (rdy_out_grant) begin
            vld_out_grant <= 1'b0;
            ptr           <= grant_des_id;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_retry_grant_sched.sv
// tb_retry_grant_sched: directed bench for retry_grant_sched with a
// cycle-level reference model compared on every falling clock edge.
module tb_retry_grant_sched;

  localparam int SW = 4;
  localparam int SN = 16;
  localparam int RN = 8;
  localparam int QC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld_rty_in = 1'b0;
  logic       rdy_rty_in;
  logic [3:0] rty_src_id = '0;
  logic [3:0] rty_qos = '0;
  logic       vld_crd_rtn = 1'b0;
  logic       vld_out_grant;
  logic       rdy_out_grant = 1'b0;
  logic [3:0] grant_des_id;
  logic [3:0] grant_qos;
  logic [3:0] crd_cnt;
  logic       crd_err;

  always #5 clk = ~clk;

  retry_grant_sched #(
    .SRC_NODE_W(SW),
    .RTY_ENTRY_NUM(RN),
    .QoS_CLASS(QC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vld_rty_in(vld_rty_in),
    .rdy_rty_in(rdy_rty_in),
    .rty_src_id(rty_src_id),
    .rty_qos(rty_qos),
    .vld_crd_rtn(vld_crd_rtn),
    .vld_out_grant(vld_out_grant),
    .rdy_out_grant(rdy_out_grant),
    .grant_des_id(grant_des_id),
    .grant_qos(grant_qos),
    .crd_cnt(crd_cnt),
    .crd_err(crd_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: per-source counters, credit pool, one grant slot.
  int mpend[SN];
  int mqos[SN];
  int mage[SN];
  int mcrd;
  int merr;
  int mvld;
  int mid;
  int mq;
  int mptr;

  function automatic int eff(input int s);
`ifdef RTY_AGING_EN
    return (mage[s] >= 15) ? QC - 1 : mqos[s];
`else
    return mqos[s];
`endif
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SN; s++) begin
      mpend[s] = 0;
      mqos[s]  = 0;
      mage[s]  = 0;
    end
    mcrd = RN; merr = 0; mvld = 0; mid = 0; mq = 0; mptr = 0;
  endfunction

  function automatic void model_step();
    int  src;
    int  best;
    int  pick;
    bit  hs;
    bit  acc;
    src  = int'(rty_src_id);
    hs   = (mvld != 0) && rdy_out_grant;
    acc  = vld_rty_in && (mpend[src] != 7);
    // new grant: highest QoS among pending, then first after last winner
    if (mvld == 0 && mcrd > 0) begin
      best = -1;
      for (int s = 0; s < SN; s++)
        if (mpend[s] > 0 && eff(s) > best) best = eff(s);
      pick = -1;
      for (int k = 1; k <= SN; k++)
        if (pick < 0 && mpend[(mptr + k) % SN] > 0 && eff((mptr + k) % SN) == best)
          pick = (mptr + k) % SN;
      if (pick >= 0) begin
        mvld = 1; mid = pick; mq = best;
      end
    end
    if (hs && !vld_crd_rtn) mcrd--;
    else if (!hs && vld_crd_rtn) begin
      if (mcrd == RN) merr = 1;
      else mcrd++;
    end
    if (hs) begin
      for (int s = 0; s < SN; s++)
        if (s != mid && mpend[s] > 0 && mage[s] < 15) mage[s]++;
      mage[mid] = 0;
      mpend[mid]--;
      mptr = mid;
      mvld = 0;
    end
    if (acc) begin
      mpend[src]++;
      mqos[src] = int'(rty_qos);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("cmp_vld", int'(vld_out_grant), mvld);
    if (mvld != 0) begin
      chk("cmp_id", int'(grant_des_id), mid);
      chk("cmp_qos", int'(grant_qos), mq);
    end
    chk("cmp_crd", int'(crd_cnt), mcrd);
    chk("cmp_err", int'(crd_err), merr);
    chk("cmp_rdy", int'(rdy_rty_in), (mpend[int'(rty_src_id)] != 7) ? 1 : 0);
  end

  int glog[$];
  always @(negedge clk)
    if (rst_n && vld_out_grant && rdy_out_grant) glog.push_back(int'(grant_des_id));

  function automatic int gl(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld_rty_in = 1'b0; vld_crd_rtn = 1'b0; rdy_out_grant = 1'b0;
    rty_src_id = '0; rty_qos = '0;
    tick(); tick();
    glog.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic retry(input int src, input int q);
    rty_src_id = 4'(src);
    rty_qos    = 4'(q);
    vld_rty_in = 1'b1;
    tick();
    vld_rty_in = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_vld", int'(vld_out_grant), 0);
    chk("rst_id", int'(grant_des_id), 0);
    chk("rst_qos", int'(grant_qos), 0);
    chk("rst_crd", int'(crd_cnt), 8);
    chk("rst_err", int'(crd_err), 0);
    chk("rst_rdy", int'(rdy_rty_in), 1);

    // single retry
    do_reset();
    retry(3, 2);
    chk("single_vld_early", int'(vld_out_grant), 0);
    tick();
    chk("single_vld", int'(vld_out_grant), 1);
    chk("single_id", int'(grant_des_id), 3);
    chk("single_qos", int'(grant_qos), 2);
    rdy_out_grant = 1'b1;
    tick();
    rdy_out_grant = 1'b0;
    chk("single_crd", int'(crd_cnt), 7);
    chk("single_cnt", glog.size(), 1);

    // QoS priority: hold a grant to src 0 while 1 and 5 queue up
    do_reset();
    retry(0, 0);
    tick();
    retry(1, 1);
    retry(5, 3);
    rdy_out_grant = 1'b1;
    repeat (10) tick();
    rdy_out_grant = 1'b0;
    chk("qos_cnt", glog.size(), 3);
    chk("qos_g1", gl(1), 5);
    chk("qos_g2", gl(2), 1);

    // round-robin from pointer 6
    do_reset();
    retry(6, 0);
    tick();
    retry(6, 0);
    retry(2, 0);
    retry(9, 0);
    rdy_out_grant = 1'b1;
    repeat (14) tick();
    rdy_out_grant = 1'b0;
    chk("rr_cnt", glog.size(), 4);
    chk("rr_g0", gl(0), 6);
    chk("rr_g1", gl(1), 9);
    chk("rr_g2", gl(2), 2);
    chk("rr_g3", gl(3), 6);

    // credit exhaustion
    do_reset();
    rdy_out_grant = 1'b1;
    for (int i = 0; i < 9; i++) retry(i, 0);
    repeat (40) tick();
    chk("exh_cnt", glog.size(), 8);
    chk("exh_crd", int'(crd_cnt), 0);
    chk("exh_vld", int'(vld_out_grant), 0);
    vld_crd_rtn = 1'b1;
    tick();
    vld_crd_rtn = 1'b0;
    repeat (10) tick();
    chk("exh_cnt9", glog.size(), 9);
    chk("exh_crd9", int'(crd_cnt), 0);
    rdy_out_grant = 1'b0;

    // overflow and backpressure
    do_reset();
    vld_crd_rtn = 1'b1;
    tick();
    vld_crd_rtn = 1'b0;
    chk("ovf_err", int'(crd_err), 1);
    chk("ovf_crd", int'(crd_cnt), 8);
    rty_src_id = 4'd4;
    #1;
    for (int i = 0; i < 7; i++) begin
      chk("bp_rdy_open", int'(rdy_rty_in), 1);
      retry(4, 1);
    end
    chk("bp_rdy_full", int'(rdy_rty_in), 0);
    vld_rty_in = 1'b1;
    tick();
    vld_rty_in = 1'b0;
    chk("bp_rdy_hold", int'(rdy_rty_in), 0);
    rdy_out_grant = 1'b1;
    repeat (30) tick();
    rdy_out_grant = 1'b0;
    chk("bp_cnt", glog.size(), 7);
    chk("bp_crd", int'(crd_cnt), 1);
    chk("bp_err_sticky", int'(crd_err), 1);

    // reset during HOLD
    do_reset();
    retry(2, 1);
    tick();
    chk("mid_vld_pre", int'(vld_out_grant), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_vld", int'(vld_out_grant), 0);
    chk("mid_id", int'(grant_des_id), 0);
    chk("mid_crd", int'(crd_cnt), 8);
    rdy_out_grant = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_cnt", glog.size(), 0);
    chk("mid_crd_post", int'(crd_cnt), 8);
    chk("mid_vld_post", int'(vld_out_grant), 0);
    rdy_out_grant = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
